// File: rtl/frame_sync_ctrl_pkg.sv
// rtl/frame_sync_ctrl_pkg.sv - shared state encoding and frame constants for frame_sync_ctrl
package frame_sync_ctrl_pkg;

    // Controller state, encoded as it appears on state_o.
    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCK   = 2'b10
    } state_t;

    localparam logic [7:0] DEF_HEADER = 8'b1100_1100;
    localparam int         FRAME_BITS = 40;
    localparam int         PAYLOAD_W  = 24;

endpackage

// File: rtl/frame_sync_ctrl_if.sv
// rtl/frame_sync_ctrl_if.sv - bit stream, control and status bundle of frame_sync_ctrl
//  ser_i/sync_flag : serial bit and its strobe (into the controller)
//  clr_cnt         : statistics clear (into the controller)
//  frame_strb/payload_o/locked/state_o/good_cnt/err_cnt : results (out of the controller)
interface frame_sync_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic             ser_i;
    logic             sync_flag;
    logic             clr_cnt;
    logic             frame_strb;
    logic [23:0]      payload_o;
    logic             locked;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output ser_i, sync_flag, clr_cnt,
        input  frame_strb, payload_o, locked, state_o, good_cnt, err_cnt
    );

    modport slave (
        input  ser_i, sync_flag, clr_cnt,
        output frame_strb, payload_o, locked, state_o, good_cnt, err_cnt
    );
endinterface

// File: rtl/frame_sync_ctrl_frame_chk.sv
// rtl/frame_sync_ctrl_frame_chk.sv - combinational header and checksum test of a 40-bit window
//  win    : candidate frame, header in [39:32], checksum in [7:0]
//  header : expected header byte
//  hdr_ok, sum_ok, good : individual and combined results
module frame_chk (
    input  logic [39:0] win,
    input  logic [7:0]  header,
    output logic        hdr_ok,
    output logic        sum_ok,
    output logic        good
);
    logic [7:0] sum;

    // 8-bit adds wrap naturally, giving the mod-256 checksum.
    assign sum    = win[39:32] + win[31:24] + win[23:16] + win[15:8];
    assign hdr_ok = (win[39:32] == header);
    assign sum_ok = (win[7:0] == sum);
    assign good   = hdr_ok && sum_ok;
endmodule

// File: rtl/frame_sync_ctrl.sv
// rtl/frame_sync_ctrl.sv - frame hunt/verify/lock controller with flywheel and statistics
//  clk : system clock
//  rst : synchronous active-high reset
//  bus : frame_sync_ctrl_if.slave (bit stream in, payload strobe, lock status, counters out)
module frame_sync_ctrl
    import frame_sync_ctrl_pkg::*;
#(
    parameter logic [7:0] HEADER     = DEF_HEADER,
    parameter int         LOCK_CNT   = 3,
    parameter int         UNLOCK_CNT = 2,
    parameter int         CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    frame_sync_ctrl_if.slave   bus
);
    localparam int                RUN_W    = 8;
    localparam logic [RUN_W-1:0]  LOCK_N   = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0]  UNLOCK_N = RUN_W'(UNLOCK_CNT);
    localparam logic [5:0]        LAST_BIT = 6'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_t                 state, state_nxt;
    logic [FRAME_BITS-1:0]  sr;
    logic [FRAME_BITS-1:0]  win;
    logic [5:0]             bit_cnt, bit_cnt_nxt;
    logic [RUN_W-1:0]       good_run, good_run_nxt;
    logic [RUN_W-1:0]       bad_run, bad_run_nxt;
    logic                   frame_strb_q;
    logic [PAYLOAD_W-1:0]   payload_q;
    logic [CNT_W-1:0]       good_cnt_q, err_cnt_q;

    logic eval, frame_good, hdr_ok, sum_ok, good_evt, bad_evt;
    logic unused_bits;

    // The window includes the incoming bit so a frame is judged on the strobe that completes it.
    assign win = {sr[FRAME_BITS-2:0], bus.ser_i};

    frame_chk u_chk (
        .win    (win),
        .header (HEADER),
        .hdr_ok (hdr_ok),
        .sum_ok (sum_ok),
        .good   (frame_good)
    );

    assign unused_bits = &{1'b0, hdr_ok, sum_ok, sr[FRAME_BITS-1]};

    // HUNT slides over every bit position; once aligned only frame boundaries are judged.
    assign eval     = bus.sync_flag && (state == ST_HUNT || bit_cnt == LAST_BIT);
    assign good_evt = eval && frame_good;
    assign bad_evt  = eval && !frame_good;

    always_comb begin
        state_nxt    = state;
        good_run_nxt = good_run;
        bad_run_nxt  = bad_run;
        bit_cnt_nxt  = bit_cnt;

        if (state != ST_HUNT && bus.sync_flag)
            bit_cnt_nxt = (bit_cnt == LAST_BIT) ? 6'd0 : bit_cnt + 6'd1;
        if (good_evt)
            bad_run_nxt = '0;

        unique case (state)
            ST_HUNT: begin
                if (good_evt) begin
                    good_run_nxt = RUN_W'(1);
                    state_nxt    = (LOCK_CNT == 1) ? ST_LOCK : ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (good_evt) begin
                    good_run_nxt = good_run + RUN_W'(1);
                    if (good_run + RUN_W'(1) == LOCK_N)
                        state_nxt = ST_LOCK;
                end else if (bad_evt) begin
                    good_run_nxt = '0;
                    state_nxt    = ST_HUNT;
                end
            end
            ST_LOCK: begin
                if (bad_evt) begin
                    bad_run_nxt = bad_run + RUN_W'(1);
                    // Flywheel: tolerate isolated bad frames, give up after a run of them.
                    if (bad_run + RUN_W'(1) == UNLOCK_N) begin
                        state_nxt    = ST_HUNT;
                        good_run_nxt = '0;
                        bad_run_nxt  = '0;
                    end
                end
            end
            default: state_nxt = ST_HUNT;
        endcase

        // Each new state starts counting bits from a fresh frame boundary.
        if (state_nxt != state)
            bit_cnt_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_HUNT;
            sr           <= '0;
            bit_cnt      <= '0;
            good_run     <= '0;
            bad_run      <= '0;
            frame_strb_q <= 1'b0;
            payload_q    <= '0;
            good_cnt_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            good_run     <= good_run_nxt;
            bad_run      <= bad_run_nxt;
            frame_strb_q <= good_evt;
            if (bus.sync_flag)
                sr <= win;
            if (good_evt)
                payload_q <= win[31:8];
            // Clear takes priority over a same-cycle increment.
            if (bus.clr_cnt)
                good_cnt_q <= '0;
            else if (good_evt && good_cnt_q != CNT_MAX)
                good_cnt_q <= good_cnt_q + CNT_W'(1);
            if (bus.clr_cnt)
                err_cnt_q <= '0;
            else if (bad_evt && state == ST_LOCK && err_cnt_q != CNT_MAX)
                err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign bus.frame_strb = frame_strb_q;
    assign bus.payload_o  = payload_q;
    assign bus.locked     = (state == ST_LOCK);
    assign bus.state_o    = state;
    assign bus.good_cnt   = good_cnt_q;
    assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_frame_sync_ctrl.sv
// tb/tb_frame_sync_ctrl.sv - randomized bench for frame_sync_ctrl with a behavioural frame model
module tb_frame_sync_ctrl;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;
    localparam int LOCK_K   = 3;
    localparam int UNLOCK_K = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_sync_ctrl_if #(.CNT_W(CW)) bus ();

    frame_sync_ctrl #(
        .HEADER     (8'hCC),
        .LOCK_CNT   (LOCK_K),
        .UNLOCK_CNT (UNLOCK_K),
        .CNT_W      (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    // Behavioural model: bit history plus frame-level bookkeeping in plain integers.
    logic [39:0] m_hist;
    int          m_state, m_pos, m_good, m_bad;
    int          e_gc, e_ec;
    logic        e_strb;
    logic [23:0] e_pay;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit frame_ok(input logic [39:0] w);
        int s;
        s = (int'(w[39:32]) + int'(w[31:24]) + int'(w[23:16]) + int'(w[15:8])) % 256;
        return (w[39:32] == 8'hCC) && (int'(w[7:0]) == s);
    endfunction

    function automatic logic [39:0] mk_frame(input logic [23:0] p);
        int s;
        s = (204 + int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0])) % 256;
        return {8'hCC, p, 8'(s)};
    endfunction

    task automatic model(input logic s, input logic b, input logic c, input logic r);
        int nxt;
        if (r) begin
            m_hist = '0; m_state = 0; m_pos = 0; m_good = 0; m_bad = 0;
            e_gc = 0; e_ec = 0; e_strb = 1'b0; e_pay = '0;
            return;
        end
        e_strb = 1'b0;
        if (s) begin
            bit judge;
            m_hist = {m_hist[38:0], b};
            judge  = (m_state == 0) || (m_pos == 39);
            if (m_state != 0) m_pos = (m_pos + 1) % 40;
            if (judge) begin
                nxt = m_state;
                if (frame_ok(m_hist)) begin
                    e_strb = 1'b1;
                    e_pay  = m_hist[31:8];
                    if (e_gc < MAXC) e_gc++;
                    m_bad = 0;
                    if (m_state == 0) begin
                        m_good = 1;
                        nxt = (LOCK_K == 1) ? 2 : 1;
                    end else if (m_state == 1) begin
                        m_good++;
                        if (m_good == LOCK_K) nxt = 2;
                    end
                end else if (m_state == 1) begin
                    m_good = 0;
                    nxt = 0;
                end else if (m_state == 2) begin
                    if (e_ec < MAXC) e_ec++;
                    m_bad++;
                    if (m_bad == UNLOCK_K) begin
                        nxt = 0; m_good = 0; m_bad = 0;
                    end
                end
                if (nxt != m_state) m_pos = 0;
                m_state = nxt;
            end
        end
        if (c) begin
            e_gc = 0;
            e_ec = 0;
        end
    endtask

    task automatic step(input logic s, input logic b, input logic c, input logic r);
        bus.sync_flag = s;
        bus.ser_i     = b;
        bus.clr_cnt   = c;
        rst           = r;
        @(posedge clk);
        model(s, b, c, r);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [39:0] v, input int nbits, input int gap);
        for (int i = nbits - 1; i >= 0; i--) begin
            repeat (gap) step(1'b0, 1'($urandom), 1'b0, 1'b0);
            step(1'b1, v[i], 1'b0, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("frame_strb", 32'(bus.frame_strb), 32'(e_strb));
            chk("payload_o",  32'(bus.payload_o),  32'(e_pay));
            chk("state_o",    32'(bus.state_o),    32'(m_state));
            chk("locked",     32'(bus.locked),     32'(m_state == 2));
            chk("good_cnt",   32'(bus.good_cnt),   32'(e_gc));
            chk("err_cnt",    32'(bus.err_cnt),    32'(e_ec));
        end
    end

    initial begin
        logic [39:0] f;
        logic [39:0] fb;
        bus.sync_flag = 1'b0;
        bus.ser_i     = 1'b0;
        bus.clr_cnt   = 1'b0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_strb", 32'(bus.frame_strb), 32'd0);

        // Single known frame acquired from HUNT
        send_word(40'hCC_12_34_56_68, 40, 0);
        chk("t1_strb", 32'(bus.frame_strb), 32'd1);
        chk("t1_payload", 32'(bus.payload_o), 32'h123456);
        chk("t1_state", 32'(bus.state_o), 32'd1);
        chk("t1_good", 32'(bus.good_cnt), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_strb_one_cycle", 32'(bus.frame_strb), 32'd0);

        // Junk then three frames to LOCK
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(40'h0, 5, 0);
        chk("t2_junk_good", 32'(bus.good_cnt), 32'd0);
        for (int k = 0; k < 3; k++) send_word(mk_frame(24'($urandom)), 40, 0);
        chk("t2_locked", 32'(bus.locked), 32'd1);
        chk("t2_good", 32'(bus.good_cnt), 32'd3);

        // Flywheel in LOCK
        send_word(40'hCC_12_34_56_69, 40, 0);
        chk("t3_bad_strb", 32'(bus.frame_strb), 32'd0);
        chk("t3_err1", 32'(bus.err_cnt), 32'd1);
        chk("t3_still_locked", 32'(bus.locked), 32'd1);
        send_word(mk_frame(24'hABCDEF), 40, 0);
        chk("t3_good_payload", 32'(bus.payload_o), 32'hABCDEF);
        send_word(40'hCC_12_34_56_69, 40, 0);
        send_word(40'hCC_00_00_00_01, 40, 0);
        chk("t3_err3", 32'(bus.err_cnt), 32'd3);
        chk("t3_unlocked", 32'(bus.locked), 32'd0);
        chk("t3_hunt", 32'(bus.state_o), 32'd0);

        // HUNT: bad-sum header ignored, then header found at an arbitrary offset
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(40'hCC_00_00_00_00, 40, 0);
        chk("t4_no_strb", 32'(bus.frame_strb), 32'd0);
        chk("t4_hunt", 32'(bus.state_o), 32'd0);
        send_word(40'h0, 13, 0);
        send_word(mk_frame(24'h5A5A01), 40, 0);
        chk("t4_offset_strb", 32'(bus.frame_strb), 32'd1);
        chk("t4_offset_payload", 32'(bus.payload_o), 32'h5A5A01);
        chk("t4_verify", 32'(bus.state_o), 32'd1);

        // Sparse strobes, then reset in the middle of a frame
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(40'hCC_12_34_56_68, 40, 2);
        chk("t5_payload", 32'(bus.payload_o), 32'h123456);
        chk("t5_state", 32'(bus.state_o), 32'd1);
        chk("t5_good", 32'(bus.good_cnt), 32'd1);
        f = mk_frame(24'h777777);
        fb = f >> 20;
        send_word(fb, 20, 2);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_rst_payload", 32'(bus.payload_o), 32'd0);
        chk("t5_rst_good", 32'(bus.good_cnt), 32'd0);
        chk("t5_rst_state", 32'(bus.state_o), 32'd0);
        send_word(f, 40, 2);
        chk("t5_reacq_payload", 32'(bus.payload_o), 32'h777777);
        chk("t5_reacq_good", 32'(bus.good_cnt), 32'd1);

        // Clear coincident with a completing good frame, then saturation
        step(1'b0, 1'b0, 1'b0, 1'b1);
        f = mk_frame(24'h0F1E2D);
        fb = f >> 1;
        send_word(fb, 39, 0);
        step(1'b1, f[0], 1'b1, 1'b0);
        chk("t6_strb", 32'(bus.frame_strb), 32'd1);
        chk("t6_good_cleared", 32'(bus.good_cnt), 32'd0);
        for (int k = 0; k < 20; k++) send_word(mk_frame(24'($urandom)), 40, 0);
        chk("t6_saturated", 32'(bus.good_cnt), 32'(MAXC));
        chk("t6_locked", 32'(bus.locked), 32'd1);

        // Randomized mix of good, corrupted and junk traffic
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int it = 0; it < 70; it++) begin
            int kind;
            int nb;
            logic [39:0] w;
            kind = $urandom_range(0, 9);
            w = mk_frame(24'($urandom));
            nb = 40;
            if (kind >= 6 && kind <= 8) w[$urandom_range(0, 39)] ^= 1'b1;
            if (kind == 9) begin
                w = {8'h0, 32'($urandom)};
                nb = $urandom_range(1, 20);
            end
            for (int i = nb - 1; i >= 0; i--) begin
                while ($urandom_range(0, 3) == 0)
                    step(1'b0, 1'($urandom), ($urandom_range(0, 60) == 0), 1'b0);
                step(1'b1, w[i], ($urandom_range(0, 80) == 0), ($urandom_range(0, 1500) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
